apb4_regbank: RTL and testbench

APB4_REGBANK -- requirements
Module: apb4_regbank

---
 rtl/apb4_pkg.sv | 30 +++
 rtl/apb4_wait_ctr.sv | 29 ++
 rtl/apb4_regbank.sv | 167 ++++++++++++++++
 tb/tb_apb4_regbank.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// apb4_pkg: shared definitions for the APB4 register bank.
//   - apb4_state_e : transfer FSM states (IDLE / ACCESS / DONE)
//   - APB4_DATA_W, APB4_STRB_W : APB4 data and byte-strobe widths
//   - apb4_merge() : byte-lane merge of write data into an old register value
package apb4_pkg;

    localparam int APB4_DATA_W = 32;
    localparam int APB4_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb4_state_e;

    // Bytes with strb set take new_v, all others keep old_v.
    function automatic logic [APB4_DATA_W-1:0] apb4_merge(
        input logic [APB4_DATA_W-1:0] old_v,
        input logic [APB4_DATA_W-1:0] new_v,
        input logic [APB4_STRB_W-1:0] strb
    );
        logic [APB4_DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < APB4_STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// apb4_wait_ctr: wait-state counter for the APB4 ACCESS phase.
// Ports:
//   pclk, preset : clock, async active-high reset
//   clr          : forces the count back to 0 on the next edge
//   tc           : terminal count, high while count == MAX
module apb4_wait_ctr #(
    parameter int MAX = 0
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    output logic tc
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 4'd1;
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == 4'(MAX));

endmodule

// File: rtl/apb4_regbank.sv
// apb4_regbank: APB4 slave with NUM_REGS 32-bit registers.
// Ports:
//   pclk, preset           : clock, async active-high reset
//   psel/penable/pwrite    : APB4 controls
//   paddr/pwdata/pstrb     : APB4 address, write data, byte strobes
//   prdata/pready/pslverr  : APB4 response
//   hw_status              : read value of read-only (RO_MASK) slots
//   reg_q                  : RW register contents (RO slots read 0)
//   wr_pulse               : one-cycle strobe per register after a committed write
// Request fields and the read value are latched at the SETUP edge, so the
// bus may change freely during ACCESS without affecting the transfer.
module apb4_regbank
    import apb4_pkg::*;
#(
    parameter int                  ADDRWIDTH   = 12,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = {NUM_REGS{1'b0}}
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDRWIDTH-1:0]         paddr,
    input  logic [APB4_DATA_W-1:0]       pwdata,
    input  logic [APB4_STRB_W-1:0]       pstrb,
    output logic [APB4_DATA_W-1:0]       prdata,
    output logic                         pready,
    output logic                         pslverr,
    input  logic [NUM_REGS*32-1:0]       hw_status,
    output logic [NUM_REGS*32-1:0]       reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int IDX_W = ADDRWIDTH - 2;

    apb4_state_e                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           wr_q, wr_d;
    logic [APB4_DATA_W-1:0]         wdata_q, wdata_d;
    logic [APB4_STRB_W-1:0]         strb_q, strb_d;
    logic                           err_q, err_d;
    logic [APB4_DATA_W-1:0]         prdata_q, prdata_d;
    logic [NUM_REGS-1:0][31:0]      regs_q, regs_d;
    logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;

    logic                           tc, ctr_clr;
    logic                           setup, pready_int, abort;
    logic [IDX_W-1:0]               idx_in;
    logic [NUM_REGS-1:0]            hit_in, hit_q;
    logic                           err_in;
    logic [APB4_DATA_W-1:0]         rd_in;

    assign setup      = psel && !penable;
    assign pready_int = (state_q == ST_ACCESS) && tc;
    // Dropping psel before the pready cycle abandons the transfer.
    assign abort      = (state_q == ST_ACCESS) && !psel && !tc;
    // Count only while an ACCESS is still waiting; restart for the next one.
    assign ctr_clr    = (state_q != ST_ACCESS) || tc || !psel;

    apb4_wait_ctr #(.MAX(WAIT_STATES)) u_wait_ctr (
        .pclk   (pclk),
        .preset (preset),
        .clr    (ctr_clr),
        .tc     (tc)
    );

    // Address decode for the incoming SETUP and for the latched index.
    always_comb begin
        idx_in = paddr[ADDRWIDTH-1:2];
        hit_in = '0;
        hit_q  = '0;
        rd_in  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_in[i] = (32'(idx_in) == 32'(i));
            hit_q[i]  = (32'(idx_q) == 32'(i));
            if (hit_in[i]) rd_in = RO_MASK[i] ? hw_status[32*i +: 32] : regs_q[i];
        end
        err_in = (paddr[1:0] != 2'b00)
              || (32'(idx_in) >= 32'(NUM_REGS))
              || (pwrite && |(hit_in & RO_MASK));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        err_d      = err_q;
        prdata_d   = prdata_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (setup) begin
                    state_d  = ST_ACCESS;
                    idx_d    = idx_in;
                    wr_d     = pwrite;
                    wdata_d  = pwdata;
                    strb_d   = pstrb;
                    err_d    = err_in;
                    prdata_d = (pwrite || err_in) ? '0 : rd_in;
                end else begin
                    state_d  = ST_IDLE;
                    prdata_d = '0;
                end
            end
            ST_ACCESS: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    prdata_d = '0;
                end else if (tc) begin
                    state_d  = ST_DONE;
                    prdata_d = '0;
                    if (wr_q && !err_q) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (hit_q[i]) begin
                                regs_d[i]     = apb4_merge(regs_q[i], wdata_q, strb_q);
                                wr_pulse_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            err_q      <= 1'b0;
            prdata_q   <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_int;
    assign pslverr  = err_q && pready_int;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb4_regbank.sv
// Directed bench for apb4_regbank: three instances with 0, 2 and 3 wait
// states share the bus; per-instance psel selects which one is addressed.
module tb_apb4_regbank;
    import apb4_pkg::*;

    localparam int NR = 16;
    localparam logic [NR-1:0] ROM = 16'h0020;

    logic             pclk = 1'b0;
    logic             preset;
    logic             psel, penable, pwrite;
    logic [11:0]      paddr;
    logic [31:0]      pwdata;
    logic [3:0]       pstrb;
    logic [NR*32-1:0] hw_status;
    logic [1:0]       sel;
    logic [2:0]       psel_v;

    logic [31:0]      prdata_a  [3];
    logic             pready_a  [3];
    logic             pslverr_a [3];
    logic [NR*32-1:0] reg_q_a   [3];
    logic [NR-1:0]    wr_pulse_a[3];

    logic [31:0]      prdata_m;
    logic             pready_m, pslverr_m;
    logic [NR*32-1:0] reg_q_m;
    logic [NR-1:0]    wr_pulse_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pclk = ~pclk;

    always_comb begin
        psel_v = 3'b000;
        case (sel)
            2'd0:    psel_v[0] = psel;
            2'd1:    psel_v[1] = psel;
            default: psel_v[2] = psel;
        endcase
        case (sel)
            2'd0: begin
                prdata_m = prdata_a[0]; pready_m = pready_a[0]; pslverr_m = pslverr_a[0];
                reg_q_m = reg_q_a[0]; wr_pulse_m = wr_pulse_a[0];
            end
            2'd1: begin
                prdata_m = prdata_a[1]; pready_m = pready_a[1]; pslverr_m = pslverr_a[1];
                reg_q_m = reg_q_a[1]; wr_pulse_m = wr_pulse_a[1];
            end
            default: begin
                prdata_m = prdata_a[2]; pready_m = pready_a[2]; pslverr_m = pslverr_a[2];
                reg_q_m = reg_q_a[2]; wr_pulse_m = wr_pulse_a[2];
            end
        endcase
    end

    apb4_regbank #(.ADDRWIDTH(12), .NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(ROM)) u0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[0]),
        .pready(pready_a[0]), .pslverr(pslverr_a[0]), .hw_status(hw_status),
        .reg_q(reg_q_a[0]), .wr_pulse(wr_pulse_a[0]));

    apb4_regbank #(.ADDRWIDTH(12), .NUM_REGS(NR), .WAIT_STATES(2), .RO_MASK(ROM)) u2 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[1]),
        .pready(pready_a[1]), .pslverr(pslverr_a[1]), .hw_status(hw_status),
        .reg_q(reg_q_a[1]), .wr_pulse(wr_pulse_a[1]));

    apb4_regbank #(.ADDRWIDTH(12), .NUM_REGS(NR), .WAIT_STATES(3), .RO_MASK(ROM)) u3 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[2]),
        .pready(pready_a[2]), .pslverr(pslverr_a[2]), .hw_status(hw_status),
        .reg_q(reg_q_a[2]), .wr_pulse(wr_pulse_a[2]));

    // Expected RW contents of u0, maintained by hand alongside the tests.
    logic [NR*32-1:0] exp0;

    task automatic setup_phase(input logic [11:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    endtask

    // Runs the ACCESS phase; returns at the negedge of the pready cycle.
    task automatic finish_xfer(output int waits, output logic [31:0] rd, output logic err);
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        while (!pready_m && waits < 40) begin
            @(negedge pclk);
            waits++;
        end
        rd  = prdata_m;
        err = pslverr_m;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        apb4_state_e st;
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            st = (k == 0) ? u0.state_q : (k == 1) ? u2.state_q : u3.state_q;
            n_tests++;
            if (prdata_m !== 32'h0 || pready_m !== 1'b0 || pslverr_m !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_resp inst%0d: prdata=%h pready=%b pslverr=%b required 0/0/0",
                         k, prdata_m, pready_m, pslverr_m);
            end
            n_tests++;
            if (reg_q_m !== '0 || wr_pulse_m !== '0) begin
                n_fail++;
                $display("FAIL reset_regs inst%0d: wr_pulse=%h reg_q nonzero, required 0", k, wr_pulse_m);
            end
            n_tests++;
            if (st !== ST_IDLE) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: state=%0d required %0d", k, st, ST_IDLE);
            end
        end
        sel = 2'd0;
    endtask

    task automatic test_zero_wait_write();
        int w; logic [31:0] rd; logic e;
        sel = 2'd0;
        setup_phase(12'h008, 1'b1, 32'hFFFF_FFFF, 4'hF);
        finish_xfer(w, rd, e);
        bus_idle();
        setup_phase(12'h008, 1'b1, 32'hA5A5_1234, 4'b0101);
        finish_xfer(w, rd, e);
        n_tests++;
        if (w !== 0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_pready: waits=%0d pslverr=%b required 0/0", w, e);
        end
        n_tests++;
        if (wr_pulse_m !== '0) begin
            n_fail++;
            $display("FAIL zw_pulse_early: wr_pulse=%h required 0", wr_pulse_m);
        end
        bus_idle();
        exp0[2*32 +: 32] = 32'hFFA5_FF34;
        n_tests++;
        if (wr_pulse_m !== 16'h0004) begin
            n_fail++;
            $display("FAIL zw_pulse: wr_pulse=%h required 0004", wr_pulse_m);
        end
        n_tests++;
        if (reg_q_m[2*32 +: 32] !== 32'hFFA5_FF34) begin
            n_fail++;
            $display("FAIL zw_merge: reg2=%h required ffa5ff34", reg_q_m[2*32 +: 32]);
        end
        @(negedge pclk);
        n_tests++;
        if (wr_pulse_m !== '0) begin
            n_fail++;
            $display("FAIL zw_pulse_len: wr_pulse=%h required 0", wr_pulse_m);
        end
    endtask

    task automatic test_waited_read();
        int w; logic [31:0] rd; logic e;
        sel = 2'd2;
        setup_phase(12'h014, 1'b0, 32'h0, 4'h0);
        finish_xfer(w, rd, e);
        n_tests++;
        if (w !== 3) begin
            n_fail++;
            $display("FAIL wr_waits: low cycles=%0d required 3", w);
        end
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_data: prdata=%h pslverr=%b required deadbeef/0", rd, e);
        end
        bus_idle();
        n_tests++;
        if (prdata_m !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_prdata_clr: prdata=%h required 0", prdata_m);
        end
    endtask

    task automatic test_errors();
        int w; logic [31:0] rd; logic e;
        logic [11:0] addrs [3];
        addrs[0] = 12'h040; addrs[1] = 12'h006; addrs[2] = 12'h014;
        sel = 2'd0;
        for (int k = 0; k < 3; k++) begin
            setup_phase(addrs[k], 1'b1, 32'h5A5A_5A5A, 4'hF);
            finish_xfer(w, rd, e);
            n_tests++;
            if (e !== 1'b1 || w !== 0) begin
                n_fail++;
                $display("FAIL err_slverr addr=%h: pslverr=%b waits=%0d required 1/0", addrs[k], e, w);
            end
            bus_idle();
            n_tests++;
            if (wr_pulse_m !== '0 || pslverr_m !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse addr=%h: wr_pulse=%h pslverr=%b required 0/0",
                         addrs[k], wr_pulse_m, pslverr_m);
            end
            n_tests++;
            if (reg_q_m !== exp0) begin
                n_fail++;
                $display("FAIL err_regs addr=%h: reg2=%h reg1=%h required unchanged (ffa5ff34/0)",
                         addrs[k], reg_q_m[2*32 +: 32], reg_q_m[1*32 +: 32]);
            end
        end
    endtask

    task automatic test_idle_penable();
        sel = 2'd0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; paddr = 12'h008; pwrite = 1'b1; pstrb = 4'hF;
        repeat (2) begin
            @(negedge pclk);
            n_tests++;
            if (u0.state_q !== ST_IDLE || pready_m !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_penable: state=%0d pready=%b required %0d/0",
                         u0.state_q, pready_m, ST_IDLE);
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_abort();
        sel = 2'd1;
        setup_phase(12'h010, 1'b1, 32'h1234_5678, 4'hF);
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        n_tests++;
        if (pready_m !== 1'b0 || pslverr_m !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_resp: pready=%b pslverr=%b required 0/0", pready_m, pslverr_m);
        end
        @(negedge pclk);
        n_tests++;
        if (u2.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL abort_state: state=%0d required %0d", u2.state_q, ST_IDLE);
        end
        n_tests++;
        if (wr_pulse_m !== '0 || pready_m !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse: wr_pulse=%h pready=%b required 0/0", wr_pulse_m, pready_m);
        end
        repeat (3) @(negedge pclk);
        n_tests++;
        if (reg_q_m !== '0) begin
            n_fail++;
            $display("FAIL abort_regs: reg4=%h required 0", reg_q_m[4*32 +: 32]);
        end
    endtask

    task automatic test_back_to_back();
        int w; logic [31:0] rd; logic e;
        sel = 2'd0;
        setup_phase(12'h00C, 1'b1, 32'hCAFE_F00D, 4'hF);
        finish_xfer(w, rd, e);
        setup_phase(12'h00C, 1'b0, 32'h0, 4'h0);
        n_tests++;
        if (u0.state_q !== ST_DONE || wr_pulse_m !== 16'h0008) begin
            n_fail++;
            $display("FAIL b2b_done: state=%0d wr_pulse=%h required %0d/0008",
                     u0.state_q, wr_pulse_m, ST_DONE);
        end
        finish_xfer(w, rd, e);
        n_tests++;
        if (w !== 0 || rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_read: waits=%0d prdata=%h pslverr=%b required 0/cafef00d/0", w, rd, e);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] rd; logic e;
        sel = 2'd2;
        setup_phase(12'h018, 1'b1, 32'h1111_1111, 4'hF);
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #1;
        n_tests++;
        if (u3.state_q !== ST_IDLE || pready_m !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: state=%0d pready=%b required %0d/0", u3.state_q, pready_m, ST_IDLE);
        end
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (4) @(negedge pclk);
        n_tests++;
        if (reg_q_m !== '0 || wr_pulse_m !== '0 || u3.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rstmid_nowrite: reg6=%h wr_pulse=%h state=%0d required 0/0/%0d",
                     reg_q_m[6*32 +: 32], wr_pulse_m, u3.state_q, ST_IDLE);
        end
        setup_phase(12'h018, 1'b0, 32'h0, 4'h0);
        finish_xfer(w, rd, e);
        n_tests++;
        if (w !== 3 || rd !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_resume: waits=%0d prdata=%h pslverr=%b required 3/0/0", w, rd, e);
        end
        bus_idle();
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sel = 2'd0;
        hw_status = '0;
        hw_status[5*32 +: 32] = 32'hDEAD_BEEF;
        exp0 = '0;
        test_reset();
        test_zero_wait_write();
        test_waited_read();
        test_errors();
        test_idle_penable();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
